cache: RTL and testbench
========================

CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have parameters: none; geometry is fixed at 2 ways, 8 sets, 16-byte lines, 9-bit tag, 3-bit index (addr[6:4]), 4-bit offset (addr[3:0]).
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 mem_read  in  1  CPU read request, held until mem_resp.
REQ-005 mem_write  in  1  CPU write request, held until mem_resp.
REQ-006 mem_byte_enable  in  2  byte mask for writes; [0] is the low byte, [1] is the high byte.
REQ-007 mem_address  in  16  CPU byte address; bit 0 is ignored for word select.
REQ-008 mem_wdata  in  16  CPU write data.
REQ-009 mem_resp  out  1  one-cycle completion pulse to the CPU.
REQ-010 mem_rdata  out  16  CPU read data, valid while mem_resp=1.
REQ-011 pmem_read  out  1  line fill request to physical memory.
REQ-012 pmem_write  out  1  line writeback request to physical memory.
REQ-013 pmem_address  out  16  line address, bits [3:0] always 0.
REQ-014 pmem_wdata  out  128  writeback line.
REQ-015 pmem_rdata  in  128  fill line.
REQ-016 pmem_resp  in  1  physical memory completion, one cycle.

Function
REQ-017 The cache SHALL be 2-way set-associative, write-back and write-allocate, with per-way valid, dirty and tag, and one LRU bit per set.
REQ-018 The FSM SHALL have exactly three states: IDLE (hit check), WRITEBACK and ALLOCATE.
REQ-019 In IDLE with a request, a hit is tag match AND valid in either way.
  - On a hit, mem_resp SHALL assert combinationally in the same cycle.
  - The hit latency is therefore 0 extra cycles after the request is seen.
REQ-020 On a read hit, mem_rdata SHALL be word addr[3:1] of the hit line.
  - mem_rdata SHALL be 16'h0000 whenever mem_resp=0.
REQ-021 On a write hit, the cache SHALL merge mem_wdata into word addr[3:1] per mem_byte_enable at the clock edge, and set dirty for that way.
REQ-022 On any hit, the cache SHALL set LRU to the way that was not hit.
REQ-023 Victim selection on a miss:
  - first invalid way (way 0 before way 1);
  - otherwise the way indicated by LRU.
REQ-024 On a miss with a dirty valid victim, the FSM SHALL go IDLE->WRITEBACK.
  - In WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim line.
  - All three are held stable until pmem_resp, then the FSM goes to ALLOCATE.
REQ-025 On a miss with a clean or invalid victim, the FSM SHALL go IDLE->ALLOCATE.
REQ-026 In ALLOCATE: pmem_read=1 and pmem_address={req tag, index, 4'h0}.
  - On pmem_resp, the cache writes pmem_rdata into the victim way, sets valid=1, dirty=0 and tag=req tag, and returns to IDLE.
  - The request then hits per REQ-019.
REQ-027 pmem_read and pmem_write SHALL never be asserted together.
  - Outside WRITEBACK/ALLOCATE, both SHALL be 0 and pmem_address SHALL be 0.
REQ-028 If mem_read and mem_write are both 1, the cache SHALL treat the request as a write.
REQ-029 An in-flight pmem transaction SHALL complete even if the CPU drops its request.
  - No CPU state (data, dirty, LRU) is updated unless a hit occurs in IDLE.
REQ-030 A pmem_resp received in IDLE SHALL be ignored.

Reset
REQ-031 rst SHALL asynchronously force:
  - state=IDLE;
  - all valid, dirty and LRU bits to 0;
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0.
REQ-032 rst asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transaction immediately, with no array update.
  - Data arrays need not be cleared.

Verification
REQ-033 Cold read miss: after reset, read 0x1234 (pmem returns a line with word 2 = 0xBEEF after 3 cycles).
  - Required: ALLOCATE with pmem_address=0x1230, then mem_resp with mem_rdata=0xBEEF; no pmem_write.
REQ-034 Write hit with mask: read 0x1234, then write 0x1234 data 0xAA55 with mask 2'b01.
  - Required: mem_resp in the same cycle; a re-read returns 0xBE55; dirty=1.
REQ-035 Dirty eviction: fill both ways of set 3 (0x0030 and 0x0230), write 0x0030, read 0x0230, then read 0x0430.
  - Required: WRITEBACK to 0x0030 first, then ALLOCATE of 0x0430 into way 0.
REQ-036 LRU: with 0x0030 and 0x0230 resident, read 0x0030, then miss on 0x0430.
  - Required: the 0x0230 way is evicted (clean, so no writeback).
REQ-037 Reset during ALLOCATE: assert rst while pmem_read=1.
  - Required: pmem_read drops in the same cycle; a subsequent read of the same address misses again.
REQ-038 Read and write both asserted on a hit: the cache performs the write, and a re-read returns the written data.

Source files
------------

// File: rtl/cache.sv
// 2-way set-associative write-back/write-allocate cache: 8 sets of 16-byte lines.
// Hits answer combinationally in IDLE. A miss writes back a dirty victim first, then fills.
module cache (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e          state_q;
    logic [127:0]    data_q [2][8];
    logic [8:0]      tag_q [2][8];
    logic [1:0][7:0] valid_q;
    logic [1:0][7:0] dirty_q;
    logic [7:0]      lru_q;
    logic            victim_q;
    logic [8:0]      req_tag_q;
    logic [2:0]      req_idx_q;

    logic [8:0]   addr_tag;
    logic [2:0]   addr_idx;
    logic [2:0]   addr_word;
    logic         req;
    logic         hit0;
    logic         hit1;
    logic         hit;
    logic         miss;
    logic         hit_way;
    logic         victim;
    logic [127:0] hit_line;
    logic [127:0] merged_line;
    logic         unused_addr_bit;

    assign addr_tag        = mem_address[15:7];
    assign addr_idx        = mem_address[6:4];
    assign addr_word       = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    assign req     = mem_read | mem_write;
    assign hit0    = valid_q[0][addr_idx] && (tag_q[0][addr_idx] == addr_tag);
    assign hit1    = valid_q[1][addr_idx] && (tag_q[1][addr_idx] == addr_tag);
    assign hit     = (state_q == StIdle) && req && (hit0 || hit1);
    assign miss    = (state_q == StIdle) && req && !(hit0 || hit1);
    assign hit_way = ~hit0;
    assign hit_line = data_q[hit_way][addr_idx];

    // LRU bit names the way to evict next.
    always_comb begin
        if (!valid_q[0][addr_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][addr_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[addr_idx];
        end
    end

    always_comb begin
        merged_line = hit_line;
        if (mem_byte_enable[0]) merged_line[{addr_word, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{addr_word, 4'h8} +: 8] = mem_wdata[15:8];
    end

    assign mem_resp   = hit;
    assign mem_rdata  = hit ? hit_line[{addr_word, 4'h0} +: 16] : 16'h0000;
    assign pmem_wdata = data_q[victim_q][req_idx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            dirty_q      <= '0;
            lru_q        <= '0;
            victim_q     <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        lru_q[addr_idx] <= ~hit_way;
                        if (mem_write) dirty_q[hit_way][addr_idx] <= 1'b1;
                    end else if (miss) begin
                        // Latch the request so the fill completes even if the CPU lets go.
                        victim_q  <= victim;
                        req_tag_q <= addr_tag;
                        req_idx_q <= addr_idx;
                        if (valid_q[victim][addr_idx] && dirty_q[victim][addr_idx]) begin
                            state_q      <= StWriteback;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_q[victim][addr_idx], addr_idx, 4'h0};
                        end else begin
                            state_q      <= StAllocate;
                            pmem_read    <= 1'b1;
                            pmem_address <= {addr_tag, addr_idx, 4'h0};
                        end
                    end
                end
                StWriteback: begin
                    if (pmem_resp) begin
                        state_q      <= StAllocate;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag_q, req_idx_q, 4'h0};
                    end
                end
                StAllocate: begin
                    if (pmem_resp) begin
                        state_q                      <= StIdle;
                        pmem_read                    <= 1'b0;
                        pmem_address                 <= '0;
                        valid_q[victim_q][req_idx_q] <= 1'b1;
                        dirty_q[victim_q][req_idx_q] <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line data and tags need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (hit && mem_write) data_q[hit_way][addr_idx] <= merged_line;
        if ((state_q == StAllocate) && pmem_resp) begin
            data_q[victim_q][req_idx_q] <= pmem_rdata;
            tag_q[victim_q][req_idx_q]  <= req_tag_q;
        end
    end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed scenarios plus random traffic against a
// line-level reference model, with a latency-programmable physical memory.
module tb_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = 2'b00;
    logic [15:0]  mem_address = 16'h0000;
    logic [15:0]  mem_wdata = 16'h0000;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    cache dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    bit inject_idle = 1'b0;
    bit pm_excl_bad = 1'b0;
    bit pm_unstable = 1'b0;

    logic [127:0] phys [int];
    bit           evt_wr [$];
    logic [15:0]  evt_addr [$];
    logic [127:0] evt_data [$];

    // Reference model: architectural line contents, per-set residency ordered LRU-first.
    logic [127:0] arch [int];
    bit           dirty_m [int];
    int           ord [8][2];
    int           n_res [8];

    function automatic logic [15:0] init_word(int la, int w);
        logic [31:0] v;
        if (la == 'h123 && w == 2) return 16'hBEEF;
        v = la * 40503 + w * 4369 + 32'h5A5A;
        return v[15:0];
    endfunction

    function automatic logic [127:0] init_line(int la);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = init_word(la, w);
        return l;
    endfunction

    function automatic logic [127:0] get_phys(int la);
        if (phys.exists(la)) return phys[la];
        return init_line(la);
    endfunction

    function automatic logic [127:0] arch_line(int la);
        if (!arch.exists(la)) arch[la] = get_phys(la);
        return arch[la];
    endfunction

    // Physical memory: answers each transaction after lat cycles.
    initial begin
        int cnt;
        int la;
        logic [15:0] start_addr;
        cnt = 0;
        start_addr = '0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) pm_excl_bad = 1'b1;
            if (rst || !(pmem_read || pmem_write)) begin
                cnt = 0;
                if (inject_idle && !rst) begin
                    pmem_rdata = '1;
                    pmem_resp = 1'b1;
                end
            end else begin
                if (cnt == 0) start_addr = pmem_address;
                else if (pmem_address !== start_addr) pm_unstable = 1'b1;
                cnt++;
                if (cnt >= lat) begin
                    la = int'(pmem_address[15:4]);
                    evt_wr.push_back(pmem_write);
                    evt_addr.push_back(pmem_address);
                    if (pmem_write) begin
                        evt_data.push_back(pmem_wdata);
                        phys[la] = pmem_wdata;
                    end else begin
                        evt_data.push_back(get_phys(la));
                        pmem_rdata = get_phys(la);
                    end
                    pmem_resp = 1'b1;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        arch.delete();
        dirty_m.delete();
        for (int s = 0; s < 8; s++) n_res[s] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cpu_access(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [1:0] be,
                              output logic [15:0] rdata, output bit got, output int waited);
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wd;
        mem_byte_enable = be;
        waited = 0;
        got = 1'b0;
        rdata = '0;
        #1;
        while (mem_resp !== 1'b1 && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (mem_resp === 1'b1) begin
            got = 1'b1;
            rdata = mem_rdata;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic model_access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                                input logic [1:0] be, output bit hit, output bit wb,
                                output logic [15:0] wb_addr, output logic [127:0] wb_line,
                                output logic [15:0] rd_word);
        int la, set, tag, w, pos, vla;
        logic [127:0] line;
        la = int'(addr[15:4]);
        set = la % 8;
        tag = la / 8;
        w = int'(addr[3:1]);
        pos = -1;
        wb = 1'b0;
        wb_addr = '0;
        wb_line = '0;
        for (int i = 0; i < n_res[set]; i++) if (ord[set][i] == tag) pos = i;
        hit = (pos >= 0);
        if (hit) begin
            if (pos == 0 && n_res[set] == 2) begin
                ord[set][0] = ord[set][1];
                ord[set][1] = tag;
            end
        end else if (n_res[set] == 2) begin
            vla = ord[set][0] * 8 + set;
            if (dirty_m.exists(vla) && dirty_m[vla]) begin
                wb = 1'b1;
                wb_addr = 16'(vla * 16);
                wb_line = arch_line(vla);
            end
            dirty_m[vla] = 1'b0;
            ord[set][0] = ord[set][1];
            ord[set][1] = tag;
        end else begin
            ord[set][n_res[set]] = tag;
            n_res[set]++;
        end
        line = arch_line(la);
        rd_word = line[w*16 +: 16];
        if (wr) begin
            if (be[0]) line[w*16 +: 8] = wd[7:0];
            if (be[1]) line[w*16+8 +: 8] = wd[15:8];
            arch[la] = line;
            dirty_m[la] = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_read = 1'b1;
        mem_address = 16'h1234;
        #1;
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp got %b want 0", mem_resp); end
        checks++; if (mem_rdata !== 16'h0) begin errors++; $display("FAIL reset_mem_rdata got %h want 0000", mem_rdata); end
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
        checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL reset_pmem_address got %h want 0000", pmem_address); end
        @(negedge clk);
        mem_read = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_cold_miss();
        logic [15:0] rd; bit got; int waited; int base;
        do_reset();
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, rd, got, waited);
        checks++; if (!got || waited == 0) begin errors++; $display("FAIL cold_latency got resp=%b wait=%0d want resp after miss", got, waited); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL cold_rdata got %h want beef", rd); end
        checks++;
        if (evt_wr.size() - base != 1 || evt_wr[base] !== 1'b0 || evt_addr[base] !== 16'h1230) begin
            errors++; $display("FAIL cold_pmem got n=%0d wr=%b addr=%h want n=1 read 1230", evt_wr.size() - base, evt_wr[base], evt_addr[base]);
        end
    endtask

    task automatic test_write_mask();
        logic [15:0] rd; bit got; int waited; int base; logic [127:0] exp_line;
        cpu_access(1'b0, 1'b1, 16'h1234, 16'hAA55, 2'b01, rd, got, waited);
        checks++; if (!got || waited != 0) begin errors++; $display("FAIL wmask_hit got resp=%b wait=%0d want same-cycle", got, waited); end
        cpu_access(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, rd, got, waited);
        checks++; if (!got || waited != 0 || rd !== 16'hBE55) begin errors++; $display("FAIL wmask_reread got %h wait=%0d want be55 wait=0", rd, waited); end
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h0234, 16'h0, 2'b00, rd, got, waited);
        checks++; if (evt_wr.size() - base != 1 || evt_wr[base] !== 1'b0) begin errors++; $display("FAIL wmask_fill2 got n=%0d want 1 read", evt_wr.size() - base); end
        exp_line = init_line('h123);
        exp_line[47:32] = 16'hBE55;
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h0434, 16'h0, 2'b00, rd, got, waited);
        checks++;
        if (evt_wr.size() - base != 2 || evt_wr[base] !== 1'b1 || evt_addr[base] !== 16'h1230 || evt_data[base] !== exp_line) begin
            errors++; $display("FAIL wmask_dirty_wb got n=%0d wr=%b addr=%h data=%h want writeback 1230 data=%h", evt_wr.size() - base, evt_wr[base], evt_addr[base], evt_data[base], exp_line);
        end
        checks++; if (rd !== init_word('h043, 2)) begin errors++; $display("FAIL wmask_evict_rdata got %h want %h", rd, init_word('h043, 2)); end
    endtask

    task automatic test_dirty_evict();
        logic [15:0] rd; bit got; int waited; int base; logic [127:0] exp_line;
        do_reset();
        cpu_access(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, rd, got, waited);
        cpu_access(1'b1, 1'b0, 16'h0230, 16'h0, 2'b00, rd, got, waited);
        cpu_access(1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, rd, got, waited);
        checks++; if (!got || waited != 0) begin errors++; $display("FAIL evict_write_hit wait=%0d want 0", waited); end
        cpu_access(1'b1, 1'b0, 16'h0230, 16'h0, 2'b00, rd, got, waited);
        exp_line = init_line('h003);
        exp_line[15:0] = 16'h1111;
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h0430, 16'h0, 2'b00, rd, got, waited);
        checks++;
        if (evt_wr.size() - base != 2 || evt_wr[base] !== 1'b1 || evt_addr[base] !== 16'h0030 || evt_data[base] !== exp_line
            || evt_wr[base+1] !== 1'b0 || evt_addr[base+1] !== 16'h0430) begin
            errors++; $display("FAIL evict_sequence got n=%0d first wr=%b addr=%h want writeback 0030 then read 0430", evt_wr.size() - base, evt_wr[base], evt_addr[base]);
        end
        checks++; if (rd !== init_word('h043, 0)) begin errors++; $display("FAIL evict_rdata got %h want %h", rd, init_word('h043, 0)); end
        cpu_access(1'b1, 1'b0, 16'h0230, 16'h0, 2'b00, rd, got, waited);
        checks++; if (!got || waited != 0) begin errors++; $display("FAIL evict_other_way_kept wait=%0d want 0", waited); end
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, rd, got, waited);
        checks++; if (evt_wr.size() - base != 1 || rd !== 16'h1111) begin errors++; $display("FAIL evict_refetch got n=%0d rdata=%h want n=1 rdata=1111", evt_wr.size() - base, rd); end
    endtask

    task automatic test_lru();
        logic [15:0] rd; bit got; int waited; int base;
        do_reset();
        cpu_access(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, rd, got, waited);
        cpu_access(1'b1, 1'b0, 16'h0230, 16'h0, 2'b00, rd, got, waited);
        cpu_access(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, rd, got, waited);
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h0430, 16'h0, 2'b00, rd, got, waited);
        checks++;
        if (evt_wr.size() - base != 1 || evt_wr[base] !== 1'b0 || evt_addr[base] !== 16'h0430) begin
            errors++; $display("FAIL lru_miss got n=%0d wr=%b addr=%h want single read 0430", evt_wr.size() - base, evt_wr[base], evt_addr[base]);
        end
        cpu_access(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, rd, got, waited);
        checks++; if (!got || waited != 0) begin errors++; $display("FAIL lru_mru_kept wait=%0d want 0", waited); end
        cpu_access(1'b1, 1'b0, 16'h0230, 16'h0, 2'b00, rd, got, waited);
        checks++; if (!got || waited == 0) begin errors++; $display("FAIL lru_victim_evicted wait=%0d want >0", waited); end
    endtask

    task automatic test_rw_both();
        logic [15:0] rd; bit got; int waited;
        do_reset();
        cpu_access(1'b1, 1'b0, 16'h0050, 16'h0, 2'b00, rd, got, waited);
        cpu_access(1'b1, 1'b1, 16'h0052, 16'hC0DE, 2'b11, rd, got, waited);
        checks++; if (!got || waited != 0) begin errors++; $display("FAIL rw_both_hit wait=%0d want 0", waited); end
        cpu_access(1'b1, 1'b0, 16'h0052, 16'h0, 2'b00, rd, got, waited);
        checks++; if (rd !== 16'hC0DE) begin errors++; $display("FAIL rw_both_reread got %h want c0de", rd); end
    endtask

    task automatic test_idle_resp();
        logic [15:0] rd; bit got; int waited;
        @(negedge clk);
        #1 inject_idle = 1'b1;
        @(negedge clk);
        #1 inject_idle = 1'b0;
        @(negedge clk);
        cpu_access(1'b1, 1'b0, 16'h0052, 16'h0, 2'b00, rd, got, waited);
        checks++; if (!got || waited != 0 || rd !== 16'hC0DE) begin errors++; $display("FAIL idle_resp_word1 got %h wait=%0d want c0de wait=0", rd, waited); end
        cpu_access(1'b1, 1'b0, 16'h0050, 16'h0, 2'b00, rd, got, waited);
        checks++; if (rd !== init_word('h005, 0)) begin errors++; $display("FAIL idle_resp_word0 got %h want %h", rd, init_word('h005, 0)); end
    endtask

    task automatic test_reset_alloc();
        logic [15:0] rd; bit got; int waited; int base;
        do_reset();
        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 16'h0670;
        waited = 0;
        #1;
        while (pmem_read !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL ralloc_start got pmem_read=%b want 1", pmem_read); end
        rst = 1'b1;
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL ralloc_drop got pmem_read=%b want 0", pmem_read); end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        base = evt_wr.size();
        cpu_access(1'b1, 1'b0, 16'h0670, 16'h0, 2'b00, rd, got, waited);
        checks++;
        if (!got || waited == 0 || evt_wr.size() - base != 1 || evt_addr[base] !== 16'h0670) begin
            errors++; $display("FAIL ralloc_remiss got wait=%0d n=%0d want miss with one fill of 0670", waited, evt_wr.size() - base);
        end
        checks++; if (rd !== init_word('h067, 0)) begin errors++; $display("FAIL ralloc_rdata got %h want %h", rd, init_word('h067, 0)); end
    endtask

    task automatic test_random();
        logic [15:0] rd, addr, wd, exp_rd, exp_wb_addr;
        logic [127:0] exp_wb_line;
        logic [8:0] tagv;
        logic [1:0] be;
        bit got, exp_hit, exp_wb, rdq, wrq;
        int waited, base, n, exp_n, kind;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            tagv = 9'($urandom_range(0, 3) * 5);
            addr = {tagv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            kind = $urandom_range(0, 2);
            rdq = (kind != 1);
            wrq = (kind != 0);
            wd = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            lat = $urandom_range(1, 4);
            model_access(wrq, addr, wd, be, exp_hit, exp_wb, exp_wb_addr, exp_wb_line, exp_rd);
            base = evt_wr.size();
            cpu_access(rdq, wrq, addr, wd, be, rd, got, waited);
            n = evt_wr.size() - base;
            exp_n = exp_hit ? 0 : (exp_wb ? 2 : 1);
            checks++;
            if (!got || ((waited == 0) != exp_hit)) begin
                errors++; $display("FAIL rand_hit addr=%h got resp=%b wait=%0d want hit=%b", addr, got, waited, exp_hit);
            end
            if (rdq && !wrq) begin
                checks++;
                if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata addr=%h got %h want %h", addr, rd, exp_rd); end
            end
            checks++;
            if (n != exp_n) begin
                errors++; $display("FAIL rand_pmem_count addr=%h got %0d want %0d", addr, n, exp_n);
            end else if (exp_n > 0) begin
                if (exp_wb) begin
                    checks++;
                    if (evt_wr[base] !== 1'b1 || evt_addr[base] !== exp_wb_addr || evt_data[base] !== exp_wb_line) begin
                        errors++; $display("FAIL rand_writeback got addr=%h data=%h want addr=%h data=%h", evt_addr[base], evt_data[base], exp_wb_addr, exp_wb_line);
                    end
                end
                checks++;
                if (evt_wr[base+n-1] !== 1'b0 || evt_addr[base+n-1] !== {addr[15:4], 4'h0}) begin
                    errors++; $display("FAIL rand_fill got wr=%b addr=%h want read %h", evt_wr[base+n-1], evt_addr[base+n-1], {addr[15:4], 4'h0});
                end
            end
        end
        checks++; if (pm_excl_bad) begin errors++; $display("FAIL pmem_exclusive got read and write together want never"); end
        checks++; if (pm_unstable) begin errors++; $display("FAIL pmem_addr_stable got address change mid-transaction want stable"); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_write_mask();
        test_dirty_evict();
        test_lru();
        test_rw_both();
        test_idle_resp();
        test_reset_alloc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
